// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder / serial_add_ctrl
//  Purpose  : Bit-serial adder. One shared full adder is stepped LSB first
//             over WIDTH cycles with a registered carry; the result is
//             presented with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================

// Single-bit full adder shared by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must hold WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int             C_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_acc_sh;
  logic               r_carry_q;
  logic [C_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic [WIDTH-1:0]   w_acc_next;

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry_q),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // The new sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign w_acc_next = w_fa_sum;
    end else begin : g_acc_wn
      assign w_acc_next = {w_fa_sum, r_acc_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_IDLE:  if (start) w_state_next = C_RUN;
      C_RUN:   if (r_cnt == C_LAST) w_state_next = C_DONE;
      C_DONE:  w_state_next = C_IDLE;
      default: w_state_next = C_IDLE;
    endcase
  end

  // Output decode from the state register only, so no input-to-output path.
  always_comb begin
    busy = (r_state != C_IDLE);
    done = (r_state == C_DONE);
  end

  // Datapath: operand capture, serial shift/accumulate, result latch on last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_acc_sh  <= '0;
      r_carry_q <= 1'b0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (start) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_carry_q <= cin;
            r_cnt     <= '0;
          end
        end
        C_RUN: begin
          r_acc_sh  <= w_acc_next;
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_carry_q <= w_fa_cout;
          r_cnt     <= r_cnt + C_CNT_W'(1);
          if (r_cnt == C_LAST) begin
            r_sum  <= w_acc_next;
            r_cout <= w_fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer that reuses a single `full_adder` instance to add two WIDTH-bit operands bit-serially, one bit per clock, LSB first. It captures the operands on a start request, runs the shared full adder for WIDTH cycles with a registered carry, and presents the result with a one-cycle done pulse. It is the area-minimal alternative to a ripple-carry chain: one full adder plus shift registers instead of WIDTH adders.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 1 to 64.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; sum and cout are valid in this cycle.
- sum  output  WIDTH  result bits; registered; held until the next result.
- cout  output  1  final carry-out; registered; held until the next result.

## Operation
- Exactly one `full_adder` instance.
  - Its inputs are a_sh[0], b_sh[0] and carry_q.
  - Its outputs are fa_sum and fa_cout.
- Internal registers: a_sh, b_sh, acc_sh (all WIDTH), carry_q, bit counter cnt (wide enough to hold WIDTH-1), state.
- States are IDLE, RUN and DONE.
- IDLE -> RUN when start=1:
  - a_sh<=a, b_sh<=b, carry_q<=cin, cnt<=0.
  - acc_sh is left as is; every bit is overwritten during RUN.
- RUN, every cycle:
  - acc_sh <= {fa_sum, acc_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1, with 0 shifted in.
  - carry_q <= fa_cout, cnt <= cnt+1.
- RUN -> DONE on the cycle where cnt==WIDTH-1 (last bit):
  - sum <= {fa_sum, acc_sh[WIDTH-1:1]}.
  - cout <= fa_cout.
- DONE -> IDLE unconditionally after one cycle. done = (state==DONE).
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Start handling:
  - start is ignored in RUN and DONE; no queuing, no error.
  - A request is accepted only if start is high in an IDLE cycle.
- Operand handling: a, b and cin are don't-care outside the accepting cycle. Changes during RUN do not affect the result.
- WIDTH=1: exactly one RUN cycle, then DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - Goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - a_sh, b_sh, acc_sh, carry_q and cnt are cleared.
  - No done pulse is produced for an aborted operation.

## Timing
- Start sampled at rising edge k (state IDLE).
- RUN occupies the cycles after edges k … k+WIDTH-1.
- DONE is entered at edge k+WIDTH.
- done is high for the cycle between edges k+WIDTH and k+WIDTH+1.
- Latency, start edge to done high: WIDTH cycles.
- busy rises after edge k and falls after edge k+WIDTH+1.
- Throughput with start held high: one result every WIDTH+2 cycles.
  - The next start is accepted at edge k+WIDTH+2, the first IDLE cycle.
- sum/cout change only at the RUN->DONE edge and at reset. They are stable from done onward until the next operation's done.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then WIDTH=8, start with a=0x00, b=0x00, cin=0:
  - done exactly 8 cycles after the start edge.
  - sum=0x00, cout=0, busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0: sum=0x00, cout=1.
- a=0xA5, b=0x5A, cin=1: sum=0x00, cout=1.
- Same test with a=0x12, b=0x34, cin=0: sum=0x46, cout=0.
  - Results stay held through the following IDLE cycles.
- start held high continuously with a=0x03, b=0x04:
  - done pulses every 10 cycles.
  - Each result is sum=0x07.
  - Toggling a and b mid-RUN does not alter the result.
  - Pulses of start while busy are ignored.
- rst_n asserted asynchronously mid-edge during cycle 4 of RUN:
  - All outputs go to 0 immediately; no done pulse.
  - A new start after deassertion gives the correct result.
- WIDTH=3 and WIDTH=1 builds, exhaustive sweep of {a,b,cin} (128 and 8 cases):
  - Every result equals a+b+cin.
  - Each done arrives WIDTH cycles after its start.
